// File: rtl/life_pkg.sv
// life_pkg: shared types, B3/S23 rule constants and the next-state rule function.
package life_pkg;

    typedef logic [3:0] ncount_t;

    localparam ncount_t BIRTH      = 4'd3;
    localparam ncount_t SURVIVE_LO = 4'd2;
    localparam ncount_t SURVIVE_HI = 4'd3;

    function automatic logic next_state(input logic alive, input ncount_t n);
        return alive ? (n >= SURVIVE_LO && n <= SURVIVE_HI) : (n == BIRTH);
    endfunction

endpackage

// File: rtl/life_next_cell.sv
// life_next_cell: combinational next state of one cell from its eight neighbours.
module life_next_cell
    import life_pkg::*;
(
    input  logic [7:0] nbr,
    input  logic       self,
    output logic       nxt
);

    ncount_t cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++)
            cnt = cnt + ncount_t'(nbr[i]);
    end

    assign nxt = next_state(self, cnt);

endmodule

// File: rtl/life_grid_param.sv
// life_grid_param: flat ROWS x COLS Game-of-Life grid with wrap/edge sourcing,
// single-step and periodic auto-run, generation counter and still-life flag.
module life_grid_param
    import life_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16,
    parameter int PER_W = 24,
    localparam int RW   = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COLS-1:0]  vali,
    input  logic [RW-1:0]    vali_selector,
    input  logic             write_enb,
    input  logic [RW-1:0]    valo_selector,
    output logic [COLS-1:0]  valo,
    output logic [COLS-1:0]  valo_prev,
    input  logic             step,
    input  logic             run,
    input  logic [PER_W-1:0] period,
    input  logic             wrap_en,
    input  logic [COLS-1:0]  ni,
    input  logic [COLS-1:0]  si,
    input  logic [ROWS-1:0]  wi,
    input  logic [ROWS-1:0]  ei,
    input  logic             nwi,
    input  logic             nei,
    input  logic             swi,
    input  logic             sei,
    output logic [COLS-1:0]  no,
    output logic [COLS-1:0]  so,
    output logic [ROWS-1:0]  wo,
    output logic [ROWS-1:0]  eo,
    output logic             nwo,
    output logic             neo,
    output logic             swo,
    output logic             seo,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable,
    output logic             step_done
);

    logic [ROWS-1:0][COLS-1:0] cur, prev, nxt;
    logic [PER_W-1:0]          pcnt;
    logic                      adv;

    // Grid padded by one cell on every side; bit 0 is column -1, bit COLS+1 is column COLS.
    logic [ROWS+1:0][COLS+1:0] ext;

    assign ext[0]      = wrap_en ? {cur[ROWS-1][0], cur[ROWS-1], cur[ROWS-1][COLS-1]} : {nei, ni, nwi};
    assign ext[ROWS+1] = wrap_en ? {cur[0][0], cur[0], cur[0][COLS-1]} : {sei, si, swi};

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign ext[r+1] = wrap_en ? {cur[r][0], cur[r], cur[r][COLS-1]} : {ei[r], cur[r], wi[r]};
        assign wo[r]    = cur[r][0];
        assign eo[r]    = cur[r][COLS-1];
        for (genvar c = 0; c < COLS; c++) begin : g_col
            life_next_cell u_cell (
                .nbr  ({ext[r][c+2:c], ext[r+1][c], ext[r+1][c+2], ext[r+2][c+2:c]}),
                .self (cur[r][c]),
                .nxt  (nxt[r][c])
            );
        end
    end

    assign no  = cur[0];
    assign so  = cur[ROWS-1];
    assign nwo = cur[0][0];
    assign neo = cur[0][COLS-1];
    assign swo = cur[ROWS-1][0];
    assign seo = cur[ROWS-1][COLS-1];

    assign valo      = (32'(valo_selector) < ROWS) ? cur[valo_selector]  : '0;
    assign valo_prev = (32'(valo_selector) < ROWS) ? prev[valo_selector] : '0;

    assign adv = step | (run & (pcnt == period));

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            prev      <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            step_done <= 1'b0;
            pcnt      <= '0;
        end else if (write_enb) begin
            // Out-of-range rows are dropped but the bookkeeping still clears.
            if (32'(vali_selector) < ROWS)
                cur[vali_selector] <= vali;
            gen_count <= '0;
            stable    <= 1'b0;
            step_done <= 1'b0;
            pcnt      <= '0;
        end else if (adv) begin
            prev      <= cur;
            cur       <= nxt;
            gen_count <= gen_count + 1'b1;
            stable    <= (nxt == cur);
            step_done <= 1'b1;
            pcnt      <= '0;
        end else begin
            step_done <= 1'b0;
            pcnt      <= run ? pcnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_life_grid_param.sv
// tb_life_grid_param: scoreboard bench; expectations are queued at stimulus time
// and compared against the grid outputs once the step/write has landed.
module tb_life_grid_param;

    localparam int ROWS = 16, COLS = 16, GEN_W = 16, PER_W = 24, RW = 4;

    logic             clk = 1'b0, reset = 1'b1;
    logic [COLS-1:0]  vali = '0, ni = '0, si = '0;
    logic [RW-1:0]    vali_selector = '0, valo_selector = '0;
    logic             write_enb = 1'b0, step = 1'b0, run = 1'b0, wrap_en = 1'b0;
    logic [PER_W-1:0] period = '0;
    logic [ROWS-1:0]  wi = '0, ei = '0;
    logic             nwi = 1'b0, nei = 1'b0, swi = 1'b0, sei = 1'b0;
    logic [COLS-1:0]  valo, valo_prev, no, so;
    logic [ROWS-1:0]  wo, eo;
    logic             nwo, neo, swo, seo, stable, step_done;
    logic [GEN_W-1:0] gen_count;

    life_grid_param #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .PER_W(PER_W)) dut (
        .clk(clk), .reset(reset), .vali(vali), .vali_selector(vali_selector),
        .write_enb(write_enb), .valo_selector(valo_selector), .valo(valo),
        .valo_prev(valo_prev), .step(step), .run(run), .period(period),
        .wrap_en(wrap_en), .ni(ni), .si(si), .wi(wi), .ei(ei),
        .nwi(nwi), .nei(nei), .swi(swi), .sei(sei),
        .no(no), .so(so), .wo(wo), .eo(eo),
        .nwo(nwo), .neo(neo), .swo(swo), .seo(seo),
        .gen_count(gen_count), .stable(stable), .step_done(step_done)
    );

    always #50 clk = ~clk;

    typedef enum int {K_ROW, K_PREV, K_GEN, K_STABLE, K_DONE, K_NO, K_PULSES} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        int          idx;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0, n_pass = 0, pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_exp(input string tag, input kind_t kind, input int idx, input logic [31:0] exp);
        sb.push_back('{tag, kind, idx, exp});
    endtask

    // Compare every queued expectation against the DUT while between clock edges.
    task automatic drain();
        sb_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            valo_selector = RW'(e.idx);
            #1;
            case (e.kind)
                K_ROW:    obs = 32'(valo);
                K_PREV:   obs = 32'(valo_prev);
                K_GEN:    obs = 32'(gen_count);
                K_STABLE: obs = 32'(stable);
                K_DONE:   obs = 32'(step_done);
                K_NO:     obs = 32'(no);
                default:  obs = 32'(pulses);
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic wr(input int row, input logic [COLS-1:0] val);
        write_enb = 1'b1;
        vali_selector = RW'(row);
        vali = val;
        cyc();
        write_enb = 1'b0;
    endtask

    task automatic stp();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    task automatic load_blinker();
        wr(7, 16'h0100);
        wr(8, 16'h0100);
        wr(9, 16'h0100);
    endtask

    initial begin
        cyc();
        do_reset();
        push_exp("rst_row", K_ROW, 8, 0);
        push_exp("rst_prev", K_PREV, 8, 0);
        push_exp("rst_gen", K_GEN, 0, 0);
        push_exp("rst_stable", K_STABLE, 0, 0);
        push_exp("rst_done", K_DONE, 0, 0);
        drain();

        load_blinker();
        stp();
        push_exp("blk_r8", K_ROW, 8, 32'h0380);
        push_exp("blk_r7", K_ROW, 7, 0);
        push_exp("blk_r9", K_ROW, 9, 0);
        push_exp("blk_prev8", K_PREV, 8, 32'h0100);
        push_exp("blk_gen", K_GEN, 0, 1);
        push_exp("blk_stable", K_STABLE, 0, 0);
        push_exp("blk_done", K_DONE, 0, 1);
        drain();
        stp();
        push_exp("blk2_r7", K_ROW, 7, 32'h0100);
        push_exp("blk2_r8", K_ROW, 8, 32'h0100);
        push_exp("blk2_prev8", K_PREV, 8, 32'h0380);
        push_exp("blk2_gen", K_GEN, 0, 2);
        drain();

        do_reset();
        wrap_en = 1'b1;
        wr(0, 16'h0007);
        stp();
        push_exp("tor_r15", K_ROW, 15, 32'h0002);
        push_exp("tor_r0", K_ROW, 0, 32'h0002);
        push_exp("tor_r1", K_ROW, 1, 32'h0002);
        drain();
        stp();
        push_exp("tor2_r0", K_ROW, 0, 32'h0007);
        push_exp("tor2_r15", K_ROW, 15, 0);
        push_exp("tor2_r1", K_ROW, 1, 0);
        drain();
        wrap_en = 1'b0;

        do_reset();
        wr(4, 16'h0030);
        wr(5, 16'h0030);
        stp();
        push_exp("blk_still_r4", K_ROW, 4, 32'h0030);
        push_exp("blk_still_r5", K_ROW, 5, 32'h0030);
        push_exp("blk_still_stable", K_STABLE, 0, 1);
        push_exp("blk_still_done", K_DONE, 0, 1);
        drain();
        cyc();
        push_exp("blk_still_done_drop", K_DONE, 0, 0);
        push_exp("blk_still_stable_hold", K_STABLE, 0, 1);
        drain();

        do_reset();
        ni = 16'h0007;
        stp();
        ni = '0;
        push_exp("edge_r0", K_ROW, 0, 32'h0002);
        push_exp("edge_no", K_NO, 0, 32'h0002);
        push_exp("edge_r1", K_ROW, 1, 0);
        drain();

        write_enb = 1'b1;
        step = 1'b1;
        vali_selector = 4'd3;
        vali = 16'h00F0;
        cyc();
        write_enb = 1'b0;
        step = 1'b0;
        push_exp("col_r3", K_ROW, 3, 32'h00F0);
        push_exp("col_r0", K_ROW, 0, 32'h0002);
        push_exp("col_gen", K_GEN, 0, 0);
        push_exp("col_done", K_DONE, 0, 0);
        drain();

        do_reset();
        load_blinker();
        period = 24'd3;
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (step_done) pulses++;
        end
        push_exp("run_pulses", K_PULSES, 0, 5);
        push_exp("run_gen", K_GEN, 0, 5);
        push_exp("run_r8", K_ROW, 8, 32'h0380);
        drain();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        push_exp("run_rst_r8", K_ROW, 8, 0);
        push_exp("run_rst_gen", K_GEN, 0, 0);
        push_exp("run_rst_done", K_DONE, 0, 0);
        drain();
        run = 1'b0;

        do_reset();
        load_blinker();
        period = '0;
        run = 1'b1;
        cyc();
        cyc();
        cyc();
        run = 1'b0;
        push_exp("p0_gen", K_GEN, 0, 3);
        push_exp("p0_r8", K_ROW, 8, 32'h0380);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/life_grid_param.md
Name: life_grid_param

Overview:
Parametrised Game-of-Life grid, ROWS x COLS cells, flat rather than built from hierarchical quadrant tiles. Supports these modes:
- Runtime edge mode: toroidal wrap, or external edge inputs for tiling.
- Free-running auto-step with a programmable period.
- Generation counter and still-life detection.

It is the next-generation replacement for the fixed 16x16 quadrant arrays and sits under the display/controller IP.

Parameters:
ROWS, 16, grid rows (>=3)
COLS, 16, grid columns, also row data width (>=3)
GEN_W, 16, generation counter width
PER_W, 24, auto-run period counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vali  in  COLS  row write data
vali_selector  in  RW=$clog2(ROWS)  row to write
write_enb  in  1  write vali into row vali_selector
valo_selector  in  RW  row to read
valo  out  COLS  current generation, selected row
valo_prev  out  COLS  previous generation, selected row
step  in  1  single-cycle request: advance one generation
run  in  1  level: auto-step every period+1 cycles
period  in  PER_W  auto-run interval minus one
wrap_en  in  1  1 = toroidal, 0 = use edge inputs
ni, si  in  COLS  neighbour row above row 0 / below row ROWS-1
wi, ei  in  ROWS  neighbour column left of col 0 / right of col COLS-1
nwi, nei, swi, sei  in  1  corner neighbours
no, so  out  COLS  row 0 / row ROWS-1
wo, eo  out  ROWS  column 0 / column COLS-1
nwo, neo, swo, seo  out  1  corner cells
gen_count  out  GEN_W  generations since reset or last write
stable  out  1  last step produced no change
step_done  out  1  one-cycle pulse when a generation was applied

Behaviour:
- Reset: all cells 0, prev grid 0, gen_count 0, stable 0, step_done 0, period counter 0. Reset overrides all other inputs.
- Cell rule: B3/S23. Neighbour count is 4 bits, so no overflow at 8.
- Neighbour sourcing:
  - wrap_en=1: row -1 = row ROWS-1, col -1 = col COLS-1, etc. Corners wrap diagonally. Edge inputs are ignored.
  - wrap_en=0: neighbours outside the grid come from ni/si/wi/ei/corner inputs. Tie these to 0 for a dead boundary.
- Bit order:
  - Column c = bit c of a row.
  - wi[r] / ei[r] are the neighbours of row r.
  - Edge outputs are combinational from the current grid.
- Read: valo/valo_prev are combinational muxes of registered state, with zero latency. An out-of-range selector returns 0.
- Write: at the clock edge with write_enb=1, row vali_selector <= vali. The prev grid is unchanged. Also on that edge:
  - gen_count <= 0
  - stable <= 0
  - the period counter clears
  - an out-of-range vali_selector discards the write but still clears.
- Step trigger (adv) = step OR (run AND period counter == period).
- Step: at the clock edge with adv=1 and write_enb=0:
  - prev <= current; current <= next
  - gen_count += 1, wrapping at 2^GEN_W
  - stable <= (next == current)
  - step_done pulses the following cycle.
  - The new grid is visible on valo the cycle after the edge.
- Simultaneous write_enb and adv: the write wins, the step is dropped, and step_done stays 0.
- Auto-run:
  - While run=1 the period counter increments each cycle.
  - It resets to 0 on adv, on write, or when run=0.
  - period=0 steps every cycle.
  - A step pulse during run forces an immediate step and restarts the interval.
- A mid-run change of wrap_en takes effect on the next step. There is no pipeline, so no flush is needed.

Decomposition:
- Package life_pkg holds:
  - the neighbour-count type (4 bits)
  - rule constants BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3
  - a function for the next-state rule.
- Sub-module life_next_cell: combinational; 8 neighbour bits + self -> next state. Instantiated ROWS*COLS times via generate.
- Top level owns the cell/prev registers, neighbour routing, counters and control.

Test Plan:
- Blinker, wrap_en=0, edges 0: write rows 7,8,9 (16x16) with only bit 8 set; step -> row 8 = 0x0380, rows 7/9 = 0. gen_count=1, stable=0, valo_prev row 8 = 0x0100.
- Toroidal wrap: write a horizontal blinker at row 0 cols 0..2 (row 0 = 0x0007), wrap_en=1; step -> rows 15,0,1 each = 0x0002. A second step restores row 0 = 0x0007.
- Block still-life, wrap_en=0: rows 4,5 = 0x0030; step -> grid unchanged, stable=1, step_done pulses exactly one cycle.
- Edge inputs: empty grid, wrap_en=0, ni=0x0007; step -> row 0 = 0x0002, and no reflects it.
- Collision: write_enb and step in the same cycle -> row written, gen_count=0, no step_done, grid not advanced.
- Auto-run: run=1, period=3 with a blinker loaded -> step_done every 4 cycles, gen_count=5 after 20 cycles. A reset asserted mid-run clears the grid, gen_count and the counter within one edge.
